// File: rtl/lut_interp_pipe.sv
// lut_interp_pipe: three-stage linear interpolator between a 16-bit function LUT and a valid/ready stream.
// Ports: clk, reset (async high); in_valid/in_ready/in_x/in_tag; lut_x -> LUT; base_sample/next_sample/frac <- LUT;
//        out_valid/out_ready/out_sample/out_tag. Build option: LUT_INTERP_ROUND_EN (round-half-up instead of floor).
`ifndef LUT_FRAC_WIDTH
`define LUT_FRAC_WIDTH 4
`endif

module lut_interp_pipe #(
  parameter int FRAC_W = `LUT_FRAC_WIDTH,
  parameter int TAG_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       in_x,
  input  logic [TAG_W-1:0]  in_tag,
  output logic [15:0]       lut_x,
  input  logic [15:0]       base_sample,
  input  logic [15:0]       next_sample,
  input  logic [FRAC_W-1:0] frac,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [15:0]       out_sample,
  output logic [TAG_W-1:0]  out_tag
);

  localparam int PW = 17 + FRAC_W + 1;

  logic              en;
  logic              v0;
  logic              v1;
  logic [TAG_W-1:0]  tag0;
  logic [TAG_W-1:0]  tag1;
  logic [15:0]       base1;
  logic [16:0]       diff1;
  logic [FRAC_W-1:0] frac1;

  logic signed [PW-1:0] d_ext;
  logic signed [PW-1:0] f_ext;
  logic signed [PW-1:0] prod;
  logic signed [PW-1:0] prod_r;
  logic [15:0]          res;

`ifdef LUT_INTERP_ROUND_EN
  localparam logic [PW-1:0] HALF = PW'(1) << (FRAC_W - 1);
`endif

  // Whole pipe moves together; a full output stage with no taker freezes it.
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  // Product is held at full width so a 17-bit diff never wraps.
  always_comb begin
    d_ext = {{(PW-17){diff1[16]}}, diff1};
    f_ext = {{(PW-FRAC_W){1'b0}}, frac1};
    prod  = d_ext * f_ext;
`ifdef LUT_INTERP_ROUND_EN
    prod_r = prod + HALF;
`else
    prod_r = prod;
`endif
    res = 16'($signed({{(PW-16){base1[15]}}, base1})
              + (prod_r >>> FRAC_W));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v0         <= 1'b0;
      v1         <= 1'b0;
      out_valid  <= 1'b0;
      lut_x      <= '0;
      tag0       <= '0;
      tag1       <= '0;
      base1      <= '0;
      diff1      <= '0;
      frac1      <= '0;
      out_sample <= '0;
      out_tag    <= '0;
    end else if (en) begin
      v0        <= in_valid;
      v1        <= v0;
      out_valid <= v1;
      if (in_valid) begin
        lut_x <= in_x;
        tag0  <= in_tag;
      end
      if (v0) begin
        base1 <= base_sample;
        diff1 <= {next_sample[15], next_sample}
               - {base_sample[15], base_sample};
        frac1 <= frac;
        tag1  <= tag0;
      end
      if (v1) begin
        out_sample <= res;
        out_tag    <= tag1;
      end
    end
  end

endmodule

// File: tb/tb_lut_interp_pipe.sv
// tb_lut_interp_pipe: bench for lut_interp_pipe with a 2048-entry LUT model indexed by lut_x.
// Directed and random streams checked against an arithmetic interpolation model.
module tb_lut_interp_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_x;
  logic [3:0]  in_tag;
  logic [15:0] lut_x;
  logic [15:0] base_sample;
  logic [15:0] next_sample;
  logic [3:0]  frac;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_sample;
  logic [3:0]  out_tag;

  lut_interp_pipe #(.FRAC_W(4), .TAG_W(4)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_tag(in_tag),
    .lut_x(lut_x),
    .base_sample(base_sample), .next_sample(next_sample),
    .frac(frac),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sample(out_sample), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  logic [15:0] tbl [2048];
  logic [10:0] li;
  logic [10:0] li1;

  always_comb begin
    li          = lut_x[14:4];
    li1         = li + 11'd1;
    base_sample = tbl[li];
    next_sample = tbl[li1];
    frac        = lut_x[3:0];
  end

  typedef struct {
    logic [15:0] s;
    logic [3:0]  t;
    int          acc;
    bit          lc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   n_out = 0;
  bit   lat_mode = 1'b0;
  bit   stream_mode = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] obs,
                     input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", nm, obs, expv);
    end
  endtask

  // Interpolation from table values with plain integer arithmetic.
  function automatic logic [15:0] ref_val(input logic [15:0] x);
    logic [10:0] i;
    logic [10:0] j;
    int b, n, f, p, fl;
    i = x[14:4];
    j = i + 11'd1;
    b = $signed(tbl[i]);
    n = $signed(tbl[j]);
    f = int'(x[3:0]);
    p = (n - b) * f;
`ifdef LUT_INTERP_ROUND_EN
    p = p + 8;
`endif
    fl = (p - (((p % 16) + 16) % 16)) / 16;
    return 16'(b + fl);
  endfunction

  task automatic load_sin();
    real s;
    for (int i = 0; i < 2048; i++) begin
      s = 32767.0 * $sin(2.0 * 3.14159265358979 * i / 2048.0);
      tbl[i] = 16'($rtoi(s >= 0.0 ? s + 0.5 : s - 0.5));
    end
  endtask

  // Scoreboard: handshakes are judged just before the edge that completes them.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (stream_mode && out_ready)
        chk("in_ready_stream", 32'(in_ready), 32'd1);
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("spurious_out", 32'(out_valid), 32'd0);
        end else begin
          e = q.pop_front();
          chk("sample", 32'(out_sample), 32'(e.s));
          chk("tag", 32'(out_tag), 32'(e.t));
          if (e.lc) chk("latency", 32'(cyc - e.acc), 32'd3);
          n_out++;
        end
      end
      if (in_valid && in_ready)
        q.push_back('{ref_val(in_x), in_tag, cyc, lat_mode});
    end
  end

  task automatic send(input logic [15:0] x, input logic [3:0] t);
    int w = 0;
    in_valid = 1'b1;
    in_x     = x;
    in_tag   = t;
    @(negedge clk);
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) chk("send_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input string nm, input logic [15:0] expv);
    int w = 0;
    @(negedge clk);
    while (!out_valid && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk({nm, "_valid"}, 32'(out_valid), 32'd1);
    chk(nm, 32'(out_sample), 32'(expv));
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int w = 0;
    idle();
    while (q.size() != 0 && w < 50) begin
      @(posedge clk);
      w++;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("drain", 32'(q.size()), 32'd0);
  endtask

  logic [15:0] hs;
  logic [3:0]  ht;
  int          n0;

  initial begin
    load_sin();
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_x      = '0;
    in_tag    = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_lut_x", 32'(lut_x), 32'd0);
    chk("rst_out_sample", 32'(out_sample), 32'd0);
    chk("rst_out_tag", 32'(out_tag), 32'd0);
    reset    = 1'b0;
    lat_mode = 1'b1;
    @(posedge clk);
    #1;

    tbl[5] = 16'h1000;
    tbl[6] = 16'h2000;
    send(16'h0058, 4'h3);
    idle();
    wait_out("basic", 16'h1800);
    drain();

    tbl[7] = 16'h7FFF;
    tbl[8] = 16'h8000;
    send(16'h007F, 4'h4);
    idle();
`ifdef LUT_INTERP_ROUND_EN
    wait_out("wide_diff", 16'h9000);
`else
    wait_out("wide_diff", 16'h8FFF);
`endif
    drain();

    tbl[9]  = 16'h1234;
    tbl[10] = 16'hABCD;
    send(16'h0090, 4'h5);
    idle();
    wait_out("frac0", 16'h1234);
    drain();

    load_sin();
    send(16'h7FF0, 4'h6);
    idle();
    wait_out("sin_end_f0", tbl[2047]);
    drain();
    send(16'h7FF8, 4'h7);
    send(16'h7FFF, 4'h8);
    drain();

    n0          = n_out;
    stream_mode = 1'b1;
    for (int i = 0; i < 100; i++)
      send(16'($urandom), 4'(i % 16));
    idle();
    stream_mode = 1'b0;
    drain();
    chk("stream_count", 32'(n_out - n0), 32'd100);

    for (int i = 0; i < 2048; i++) tbl[i] = 16'($urandom);
    n0 = n_out;
    for (int i = 0; i < 60; i++)
      send(16'($urandom), 4'($urandom));
    drain();
    chk("rand_tbl_count", 32'(n_out - n0), 32'd60);
    load_sin();

    lat_mode = 1'b0;
    n0       = n_out;
    for (int i = 0; i < 4; i++)
      send(16'($urandom), 4'(i));
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_x      = 16'h2345;
    in_tag    = 4'hA;
    @(negedge clk);
    hs = out_sample;
    ht = out_tag;
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      if (i > 0) begin
        chk("stall_sample", 32'(out_sample), 32'(hs));
        chk("stall_tag", 32'(out_tag), 32'(ht));
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(16'h2345, 4'hA);
    send(16'h4000, 4'hB);
    drain();
    chk("bp_count", 32'(n_out - n0), 32'd6);
    lat_mode = 1'b1;

    out_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      send(16'($urandom), 4'(i + 12));
    idle();
    #2;
    reset = 1'b1;
    #1;
    chk("rst_mid_out_valid", 32'(out_valid), 32'd0);
    chk("rst_mid_in_ready", 32'(in_ready), 32'd1);
    chk("rst_mid_lut_x", 32'(lut_x), 32'd0);
    chk("rst_mid_sample", 32'(out_sample), 32'd0);
    q.delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    reset     = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("no_stale", 32'(out_valid), 32'd0);
    end
    @(posedge clk);
    #1;
    n0 = n_out;
    send(16'h0100, 4'h1);
    idle();
    wait_out("post_rst", ref_val(16'h0100));
    drain();
    chk("post_rst_count", 32'(n_out - n0), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
